bcd_serial_add_ctrl: RTL and testbench

//  Sequencer for one shared single-digit BCD adder (4-bit digits, decimal-corrected, carry in/out).

---
 rtl/bcd_serial_add_ctrl_if.sv | 25 ++
 rtl/bcd_serial_add_ctrl.sv | 137 +++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_add_ctrl_if.sv
// Requester-side start/done handshake for bcd_serial_add_ctrl.
// The master drives operands and start; the slave returns status and the registered result.
interface bcd_serial_add_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder sequencer driving one external decimal digit adder, LSD first.
// Optional macro BCD_CHECK_EN: reject operands holding a digit > 9 (err=1, sum=0, no RUN).
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    bcd_serial_add_ctrl_if.slave req,
    output logic [3:0]          dig_a_o,
    output logic [3:0]          dig_b_o,
    output logic                dig_cin_o,
    input  logic [3:0]          dig_s_i,
    input  logic                dig_cout_i
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = $clog2(DIGITS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              accept;
    logic              last;
    logic              skip_run;

`ifdef BCD_CHECK_EN
    logic err_q, err_d;
    logic bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (req.a[4*i +: 4] > 4'd9 || req.b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end
    assign skip_run = bad_digit;
`else
    assign skip_run = 1'b0;
`endif

    // Start is only honoured when no operation is in flight.
    assign accept = req.start && (state_q == StIdle || state_q == StDone);
    assign last   = (idx_q == IdxW'(DIGITS - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef BCD_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef BCD_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef BCD_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = skip_run ? StDone : StRun;
                    a_d     = req.a;
                    b_d     = req.b;
                    carry_d = req.cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef BCD_CHECK_EN
                    err_d   = bad_digit;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sum_d[4*idx_q +: 4] = dig_s_i;
                carry_d             = dig_cout_i;
                idx_d               = idx_q + 1'b1;
                if (last) begin
                    cout_d  = dig_cout_i;
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req.busy  = (state_q == StRun);
        req.done  = (state_q == StDone);
        req.sum   = sum_q;
        req.cout  = cout_q;
`ifdef BCD_CHECK_EN
        req.err   = err_q;
`else
        req.err   = 1'b0;
`endif
        dig_a_o   = 4'd0;
        dig_b_o   = 4'd0;
        dig_cin_o = 1'b0;
        if (state_q == StRun) begin
            dig_a_o   = a_q[4*idx_q +: 4];
            dig_b_o   = b_q[4*idx_q +: 4];
            dig_cin_o = carry_q;
        end
    end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl (DIGITS=4) with a behavioural decimal digit adder.
module tb_bcd_serial_add_ctrl;
    localparam int unsigned DIGITS = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  dig_a, dig_b, dig_s;
    logic        dig_cin, dig_cout;
    logic [4:0]  raw, fixed;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    exp_t        exp_q[$];

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req        (bus),
        .dig_a_o    (dig_a),
        .dig_b_o    (dig_b),
        .dig_cin_o  (dig_cin),
        .dig_s_i    (dig_s),
        .dig_cout_i (dig_cout)
    );

    // External single-digit decimal adder.
    always_comb begin
        raw   = 5'(dig_a) + 5'(dig_b) + 5'(dig_cin);
        fixed = raw + 5'd6;
        if (raw > 5'd9) begin
            dig_s    = fixed[3:0];
            dig_cout = 1'b1;
        end else begin
            dig_s    = raw[3:0];
            dig_cout = 1'b0;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum",  {16'd0, bus.sum}, {16'd0, e.sum});
                check("cout", {31'd0, bus.cout}, {31'd0, e.cout});
                check("err",  {31'd0, bus.err}, {31'd0, e.err});
            end
        end
    end

    // Called at a negedge: present operands with start high and record the expectation.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] s, input logic co, input logic er);
        exp_t e;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        e.sum     = s;
        e.cout    = co;
        e.err     = er;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          lat, bc, d0;
        logic [3:0]  cins;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum",  {16'd0, bus.sum},  32'd0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        check("rst_err",  {31'd0, bus.err},  32'd0);
        check("rst_dig",  {23'd0, dig_a, dig_b, dig_cin}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic add with latency and busy duration
        issue(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        wait_done(lat, bc);
        check("t1_latency", lat, 32'd5);
        check("t1_busy_cycles", bc, 32'd4);
        @(negedge clk);

        // 2: full ripple; carry register seen by the digit adder
        issue(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        cins = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check("t2_dig_cin", {31'd0, dig_cin}, {31'd0, cins[k]});
        end
        wait_done(lat, bc);
        check("t2_latency", lat, 32'd1);
        @(negedge clk);

        // 3: carry-in only, then back-to-back accept from DONE
        issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        wait_done(lat, bc);
        issue(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);
        wait_done(lat, bc);
        check("t3_b2b_latency", lat, 32'd5);
        check("t3_b2b_busy", bc, 32'd4);
        @(negedge clk);

        // 4: start pulsed mid-RUN with other operands is ignored
        d0 = done_cnt;
        issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a     = 16'h9999;
        bus.b     = 16'h9999;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_done_pulses", done_cnt - d0, 32'd1);

        // 5: reset while RUN at idx 2 aborts without a done pulse
        bus.a     = 16'h1234;
        bus.b     = 16'h5678;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_sum",  {16'd0, bus.sum},  32'd0);
        check("t5_cout", {31'd0, bus.cout}, 32'd0);
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 32'd0);

        // 6: operand with a non-BCD digit
`ifdef BCD_CHECK_EN
        issue(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
        wait_done(lat, bc);
        check("t6_latency", lat, 32'd1);
        check("t6_busy_cycles", bc, 32'd0);
        @(negedge clk);
        check("t6_err_held", {31'd0, bus.err}, 32'd1);
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        wait_done(lat, bc);
        check("t6_clear_latency", lat, 32'd5);
`else
        issue(16'h12A4, 16'h0001, 1'b0, 16'h1305, 1'b0, 1'b0);
        wait_done(lat, bc);
        check("t6_latency", lat, 32'd5);
        check("t6_err_low", {31'd0, bus.err}, 32'd0);
`endif
        @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
